control_unit_legv8: RTL

CONTROL_UNIT_LEGV8 -- requirements
Module: control_unit_legv8

---
 rtl/control_unit_legv8.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 control unit: accepts one instruction per IDLE visit and
// sequences decode, execute, memory and writeback strobes for the datapath.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | instr_ready high, waiting for an instruction
// DECODE    | classify latched word, load ALU controls, flag illegal ops
// EXECUTE   | ALU cycle; branches resolve here
// MEMORY    | hold mem_rd / mem_wr until mem_ready
// WRITEBACK | register write and PC increment
module control_unit_legv8 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic [4:0]  alu_fs,
  output logic        alu_c0,
  output logic [1:0]  alu_b_sel,
  output logic [4:0]  rd_a_addr,
  output logic [4:0]  rd_b_addr,
  output logic [4:0]  wr_addr,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        pc_src,
  output logic        illegal
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK} state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_I, C_LD, C_ST, C_CB, C_B} cls_t;

  state_t      state, state_nxt;
  cls_t        cls_q, d_cls;
  logic [31:0] instr_q;
  logic        cbnz_q;
  logic [4:0]  d_fs, d_ra, d_rb;
  logic        d_c0;
  logic [1:0]  d_bsel;
  logic        taken;
  logic        unused_bits;

  assign unused_bits = ^{status[3:1], instr_q[15:10]};
  assign instr_ready = (state == S_IDLE);

  // Longest prefix first; the patterns do not overlap, so order is only for readability.
  always_comb begin
    d_cls  = C_ILL;
    d_fs   = 5'b00000;
    d_c0   = 1'b0;
    d_bsel = 2'b00;
    d_ra   = instr_q[9:5];
    d_rb   = instr_q[20:16];
    casez (instr_q[31:21])
      11'b10001011000: begin d_cls = C_R;  d_fs = 5'b01000; end
      11'b11001011000: begin d_cls = C_R;  d_fs = 5'b01010; d_c0 = 1'b1; end
      11'b10001010000: begin d_cls = C_R;  d_fs = 5'b00000; end
      11'b10101010000: begin d_cls = C_R;  d_fs = 5'b00100; end
      11'b11001010000: begin d_cls = C_R;  d_fs = 5'b01100; end
      11'b11010011011: begin d_cls = C_R;  d_fs = 5'b10000; d_bsel = 2'b11; end
      11'b11010011010: begin d_cls = C_R;  d_fs = 5'b10100; d_bsel = 2'b11; end
      11'b11111000010: begin d_cls = C_LD; d_fs = 5'b01000; d_bsel = 2'b10; end
      11'b11111000000: begin d_cls = C_ST; d_fs = 5'b01000; d_bsel = 2'b10; end
      11'b1001000100?: begin d_cls = C_I;  d_fs = 5'b01000; d_bsel = 2'b01; end
      11'b1101000100?: begin d_cls = C_I;  d_fs = 5'b01010; d_bsel = 2'b01; d_c0 = 1'b1; end
      11'b1011010????: begin d_cls = C_CB; d_fs = 5'b00100; end
      11'b000101?????: begin d_cls = C_B; end
      default:         d_cls = C_ILL;
    endcase
    if (d_cls == C_CB) begin
      d_ra = instr_q[4:0];
      d_rb = 5'd31;
    end else if (d_cls == C_ST) begin
      d_rb = instr_q[4:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q   <= '0;
      cls_q     <= C_ILL;
      cbnz_q    <= 1'b0;
      alu_fs    <= '0;
      alu_c0    <= 1'b0;
      alu_b_sel <= '0;
      rd_a_addr <= '0;
      rd_b_addr <= '0;
      wr_addr   <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) instr_q <= instr;
      // Controls load once per instruction and stay put until the next decode.
      if (state == S_DECODE) begin
        cls_q     <= d_cls;
        cbnz_q    <= instr_q[24];
        alu_fs    <= d_fs;
        alu_c0    <= d_c0;
        alu_b_sel <= d_bsel;
        rd_a_addr <= d_ra;
        rd_b_addr <= d_rb;
        wr_addr   <= instr_q[4:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (instr_valid) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = (d_cls == C_ILL) ? S_IDLE : S_EXECUTE;
      S_EXECUTE: begin
        case (cls_q)
          C_R, C_I:   state_nxt = S_WRITEBACK;
          C_LD, C_ST: state_nxt = S_MEMORY;
          default:    state_nxt = S_IDLE;
        endcase
      end
      S_MEMORY:    if (mem_ready) state_nxt = (cls_q == C_LD) ? S_WRITEBACK : S_IDLE;
      S_WRITEBACK: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  assign taken = status[0] ^ cbnz_q;

  always_comb begin
    reg_we  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    pc_src  = 1'b0;
    illegal = 1'b0;
    case (state)
      S_DECODE:  illegal = (d_cls == C_ILL);
      S_EXECUTE: begin
        if (cls_q == C_B) begin
          pc_load = 1'b1;
          pc_src  = 1'b1;
        end else if (cls_q == C_CB) begin
          pc_load = taken;
          pc_inc  = ~taken;
        end
      end
      S_MEMORY: begin
        mem_rd = (cls_q == C_LD);
        mem_wr = (cls_q == C_ST);
        pc_inc = (cls_q == C_ST) && mem_ready;
      end
      S_WRITEBACK: begin
        reg_we = (wr_addr != 5'd31);
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
